regfile_mp: RTL and testbench

//  Next-generation integer register file for the RV32I core. It has NR synchronous read ports,

---
 rtl/regfile_mp.sv | 119 +++++++++++
 tb/tb_regfile_mp.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// ---------------------------------------------------------------------------
// regfile_mp : RV32I register file, NR sync read ports, bypass, pending-write
//              scoreboard, self-clearing sweep after reset.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module regfile_mp #(
  parameter int XLEN   = 32,
  parameter int N      = 32,
  parameter int A      = $clog2(N),
  parameter int NR     = 2,
  parameter int BYPASS = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               ready,
  input  logic               we,
  input  logic [A-1:0]       addrw,
  input  logic [XLEN-1:0]    dataw,
  input  logic               re,
  input  logic [NR*A-1:0]    raddr,
  output logic [NR*XLEN-1:0] rdata,
  input  logic               pend_set,
  input  logic [A-1:0]       pend_addr,
  output logic [NR-1:0]      busy
);

  typedef enum logic [0:0] {
    S_CLEAR = 1'b0,
    S_RUN   = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [A-1:0]        cnt_q, cnt_d;
  logic [XLEN-1:0]     rf_q [1:N-1];
  logic [XLEN-1:0]     rf_d [1:N-1];
  logic [N-1:1]        pend_q, pend_d;
  logic [NR*XLEN-1:0]  rdata_q, rdata_d;

  logic [A-1:0]        rd_addr [NR];
  logic [NR-1:0]       hit;
  logic                wr_en;

  // x0 and addresses beyond the last register have no storage
  function automatic logic valid_addr(input logic [A-1:0] a);
    return (a != '0) && (int'(a) < N);
  endfunction

  assign ready = (state_q == S_RUN);
  assign rdata = rdata_q;
  assign wr_en = ready && we && valid_addr(addrw);

  for (genvar k = 0; k < NR; k++) begin : g_port
    assign rd_addr[k] = raddr[k*A +: A];
    assign hit[k]     = (BYPASS != 0) && wr_en && (addrw == rd_addr[k]);
    assign busy[k]    = ready && valid_addr(rd_addr[k]) && pend_q[rd_addr[k]] && !hit[k];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rf_d    = rf_q;
    pend_d  = pend_q;
    rdata_d = rdata_q;
    case (state_q)
      S_CLEAR: begin
        rf_d[cnt_q] = '0;
        cnt_d       = cnt_q + 1'b1;
        if (int'(cnt_q) == N - 1) begin
          state_d = S_RUN;
        end
      end
      default: begin
        if (re) begin
          for (int k = 0; k < NR; k++) begin
            if (!valid_addr(rd_addr[k])) begin
              rdata_d[k*XLEN +: XLEN] = '0;
            end else if (hit[k]) begin
              rdata_d[k*XLEN +: XLEN] = dataw;
            end else begin
              rdata_d[k*XLEN +: XLEN] = rf_q[rd_addr[k]];
            end
          end
        end
        if (wr_en) begin
          rf_d[addrw]   = dataw;
          pend_d[addrw] = 1'b0;
        end
        // a same-cycle pend_set marks a new outstanding load, so it wins
        if (pend_set && valid_addr(pend_addr)) begin
          pend_d[pend_addr] = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_CLEAR;
      cnt_q   <= A'(1);
      pend_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      rdata_q <= rdata_d;
    end
  end

  // storage needs no reset: the sweep clears it before ready rises
  always_ff @(posedge clk) begin
    rf_q <= rf_d;
  end

endmodule

`default_nettype wire

// File: tb/tb_regfile_mp.sv
// ---------------------------------------------------------------------------
// tb_regfile_mp : randomized self-checking bench for regfile_mp.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_regfile_mp;

  localparam int XLEN   = 32;
  localparam int N      = 32;
  localparam int A      = 5;
  localparam int NR     = 2;
  localparam int BYPASS = 1;

  logic              clk;
  logic              rst_n;
  logic              ready;
  logic              we;
  logic [A-1:0]      addrw;
  logic [XLEN-1:0]   dataw;
  logic              re;
  logic [NR*A-1:0]   raddr;
  logic [NR*XLEN-1:0] rdata;
  logic              pend_set;
  logic [A-1:0]      pend_addr;
  logic [NR-1:0]     busy;

  regfile_mp #(.XLEN(XLEN), .N(N), .A(A), .NR(NR), .BYPASS(BYPASS)) u_dut (
    .clk(clk), .rst_n(rst_n), .ready(ready),
    .we(we), .addrw(addrw), .dataw(dataw),
    .re(re), .raddr(raddr), .rdata(rdata),
    .pend_set(pend_set), .pend_addr(pend_addr), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model
  logic [XLEN-1:0] m_mem [N];
  bit   [N-1:0]    m_pend;
  logic [XLEN-1:0] m_rd [NR];
  bit              m_ready;
  int              m_edges;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_ready = 1'b0;
    m_edges = 0;
    m_pend  = '0;
    for (int k = 0; k < NR; k++) m_rd[k] = '0;
  endtask

  // entered and left 1 time unit after a rising edge
  task automatic do_reset();
    rst_n = 1'b0;
    we = 1'b0; re = 1'b0; pend_set = 1'b0;
    model_reset();
    #1;
    check("rst_ready", {31'd0, ready}, '0);
    check("rst_rdata0", rdata[0 +: XLEN], '0);
    check("rst_rdata1", rdata[XLEN +: XLEN], '0);
    check("rst_busy", {30'd0, busy}, '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic cycle(input logic i_we, input logic [A-1:0] i_aw, input logic [XLEN-1:0] i_dw,
                       input logic i_re, input logic [A-1:0] i_r0, input logic [A-1:0] i_r1,
                       input logic i_ps, input logic [A-1:0] i_pa);
    logic [A-1:0] ra [NR];
    bit exp_busy;
    ra[0] = i_r0;
    ra[1] = i_r1;
    we = i_we; addrw = i_aw; dataw = i_dw;
    re = i_re; raddr = {i_r1, i_r0};
    pend_set = i_ps; pend_addr = i_pa;
    @(negedge clk);
    for (int k = 0; k < NR; k++) begin
      exp_busy = m_ready && (ra[k] != 0) && m_pend[ra[k]]
                 && !(BYPASS != 0 && i_we && i_aw == ra[k]);
      check(k == 0 ? "busy0" : "busy1", {31'd0, busy[k]}, {31'd0, exp_busy});
    end
    if (m_ready) begin
      if (i_re) begin
        for (int k = 0; k < NR; k++) begin
          if (ra[k] == 0) m_rd[k] = '0;
          else if (BYPASS != 0 && i_we && i_aw == ra[k]) m_rd[k] = i_dw;
          else m_rd[k] = m_mem[ra[k]];
        end
      end
      if (i_we && i_aw != 0) begin
        m_mem[i_aw]  = i_dw;
        m_pend[i_aw] = 1'b0;
      end
      if (i_ps && i_pa != 0) m_pend[i_pa] = 1'b1;
    end else begin
      m_edges++;
      if (m_edges == N - 1) begin
        m_ready = 1'b1;
        for (int i = 0; i < N; i++) m_mem[i] = '0;
      end
    end
    @(posedge clk);
    #1;
    check("rdata0", rdata[0 +: XLEN], m_rd[0]);
    check("rdata1", rdata[XLEN +: XLEN], m_rd[1]);
    check("ready", {31'd0, ready}, {31'd0, m_ready});
  endtask

  function automatic logic [A-1:0] pick();
    if ($urandom_range(0, 1) == 1) return A'($urandom_range(0, 7));
    return A'($urandom_range(0, N - 1));
  endfunction

  task automatic rnd_cycle();
    cycle(1'($urandom_range(0, 1)), pick(), $urandom(),
          1'($urandom_range(0, 3) != 0), pick(), pick(),
          1'($urandom_range(0, 3) == 0), pick());
  endtask

  task automatic sweep();
    for (int i = 0; i < N - 1; i++) rnd_cycle();
  endtask

  task automatic read_all();
    for (int i = 0; i < N; i += 2) cycle(1'b0, '0, '0, 1'b1, A'(i), A'(i + 1), 1'b0, '0);
  endtask

  initial begin
    rst_n = 1'b1;
    we = 1'b0; addrw = '0; dataw = '0; re = 1'b0; raddr = '0;
    pend_set = 1'b0; pend_addr = '0;
    model_reset();
    @(posedge clk);
    #1;
    do_reset();
    sweep();
    read_all();

    // directed scenarios
    cycle(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0);
    cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 5'd0, 1'b0, 5'd0);
    cycle(1'b1, 5'd7, 32'h12345678, 1'b1, 5'd7, 5'd7, 1'b0, 5'd0);
    cycle(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0);
    cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd0, 1'b1, 5'd0);
    cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd0, 1'b0, 5'd0);
    cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 1'b1, 5'd9);
    cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd9, 1'b0, 5'd0);
    cycle(1'b1, 5'd9, 32'hA5A5A5A5, 1'b1, 5'd0, 5'd9, 1'b0, 5'd0);
    cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd9, 1'b0, 5'd0);
    cycle(1'b1, 5'd9, 32'h5A5A5A5A, 1'b1, 5'd9, 5'd9, 1'b1, 5'd9);
    cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd9, 1'b0, 5'd0);

    for (int i = 0; i < 400; i++) rnd_cycle();

    // reset mid-sweep, then again in RUN after traffic
    do_reset();
    for (int i = 0; i < 10; i++) rnd_cycle();
    do_reset();
    sweep();
    for (int i = 0; i < 100; i++) rnd_cycle();
    do_reset();
    sweep();
    read_all();
    for (int i = 0; i < 200; i++) rnd_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
